// File: rtl/alu_req_sched.sv
// Round-robin request scheduler in front of the shared 8-bit ALU.
// Issues one operation at a time and returns results on a tagged response channel.
module alu_req_sched #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_mode,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_mode,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_op1,
    output logic [7:0]  rsp_op2,
    output logic [15:0] rsp_op3,
    output logic        rsp_err,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_mode,
    input  logic [7:0]  alu_op1,
    input  logic [7:0]  alu_op2,
    input  logic [15:0] alu_op3,
    input  logic        alu_done,
    output logic        busy
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
    localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q;
    logic        lastGrant_q;
    logic [3:0]  settleCnt_q;
    logic [7:0]  waitCnt_q;
    logic [8:0]  waitCnt_d;
    logic [7:0]  aluA_q;
    logic [7:0]  aluB_q;
    logic [2:0]  aluMode_q;
    logic        rspId_q;
    logic [7:0]  rspOp1_q;
    logic [7:0]  rspOp2_q;
    logic [15:0] rspOp3_q;
    logic        rspErr_q;
    logic        grant0;
    logic        grant1;

    // On a tie the port that did not win last time gets the grant.
    assign grant0     = req0_valid && (!req1_valid || lastGrant_q);
    assign grant1     = req1_valid && (!req0_valid || !lastGrant_q);
    assign req0_ready = (state_q == ST_IDLE) && grant0;
    assign req1_ready = (state_q == ST_IDLE) && grant1;

    assign waitCnt_d  = {1'b0, waitCnt_q} + 9'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lastGrant_q <= 1'b1;
            settleCnt_q <= '0;
            waitCnt_q   <= '0;
            aluA_q      <= '0;
            aluB_q      <= '0;
            aluMode_q   <= '0;
            rspId_q     <= 1'b0;
            rspOp1_q    <= '0;
            rspOp2_q    <= '0;
            rspOp3_q    <= '0;
            rspErr_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        aluA_q      <= req1_ready ? req1_a : req0_a;
                        aluB_q      <= req1_ready ? req1_b : req0_b;
                        aluMode_q   <= req1_ready ? req1_mode : req0_mode;
                        lastGrant_q <= req1_ready;
                        settleCnt_q <= SETTLE_LOAD;
                        state_q     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    settleCnt_q <= settleCnt_q - 4'd1;
                    if (settleCnt_q == 4'd1) begin
                        waitCnt_q <= '0;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // done may still be high from the previous op, so it is only trusted here.
                    if (alu_done) begin
                        rspId_q  <= lastGrant_q;
                        rspOp1_q <= alu_op1;
                        rspOp2_q <= alu_op2;
                        rspOp3_q <= alu_op3;
                        rspErr_q <= 1'b0;
                        state_q  <= ST_RESP;
                    end else begin
                        waitCnt_q <= waitCnt_d[7:0];
                        if (waitCnt_d == TIMEOUT_CNT) begin
                            rspId_q  <= lastGrant_q;
                            rspOp1_q <= '0;
                            rspOp2_q <= '0;
                            rspOp3_q <= '0;
                            rspErr_q <= 1'b1;
                            state_q  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_id    = rspId_q;
    assign rsp_op1   = rspOp1_q;
    assign rsp_op2   = rspOp2_q;
    assign rsp_op3   = rspOp3_q;
    assign rsp_err   = rspErr_q;
    assign alu_a     = aluA_q;
    assign alu_b     = aluB_q;
    assign alu_mode  = aluMode_q;

endmodule

// File: tb/tb_alu_req_sched.sv
// Directed testbench for alu_req_sched with a small behavioural ALU whose
// done flag timing is selectable per scenario.
module tb_alu_req_sched;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_mode = '0, req1_mode = '0;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [7:0]  rsp_op1, rsp_op2;
    logic [15:0] rsp_op3;
    logic        rsp_err;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_mode;
    logic [7:0]  alu_op1, alu_op2;
    logic [15:0] alu_op3;
    logic        alu_done;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    // 0: done low, 1: done stuck high, 2: done from the first WAIT cycle of each op
    int doneMode  = 2;
    int sinceAcc  = 255;

    logic [8:0]  sum;
    logic [15:0] prod;

    always #5 clk = ~clk;

    alu_req_sched #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_op1(rsp_op1), .rsp_op2(rsp_op2), .rsp_op3(rsp_op3), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op3(alu_op3),
        .alu_done(alu_done), .busy(busy)
    );

    // Behavioural ALU: add carries into op2, mul fills op3, div gives quotient/remainder.
    always_comb begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b};
        prod    = alu_a * alu_b;
        alu_op1 = '0;
        alu_op2 = '0;
        alu_op3 = '0;
        case (alu_mode)
            3'b000: begin alu_op1 = sum[7:0]; alu_op2 = {7'd0, sum[8]}; end
            3'b010: alu_op3 = prod;
            3'b011: if (alu_b != 8'd0) begin alu_op1 = alu_a / alu_b; alu_op2 = alu_a % alu_b; end
            default: alu_op1 = alu_a & alu_b;
        endcase
    end

    // Cycles since the last accept edge, used to place done relative to the issue.
    always @(posedge clk) begin
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
            sinceAcc <= 0;
        else if (sinceAcc < 255)
            sinceAcc <= sinceAcc + 1;
    end

    assign alu_done = (doneMode == 1) || (doneMode == 2 && sinceAcc >= SETTLE);

    task automatic resetDut;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    // Presents a request and waits (bounded) for its accept edge.
    task automatic issue(input bit port, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        bit got = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_mode = m; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_mode = m; req0_a = a; req0_b = b;
        end
        for (int i = 0; i < 100 && !got; i++) begin
            #1 got = port ? req1_ready : req0_ready;
            if (!got) @(negedge clk);
        end
        compared++;
        if (!got) begin
            mismatched++;
            $display("[TB] FAIL issue_ready port%0d: ready=%0b required=1", port, got);
        end
        @(posedge clk);
        #1;
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until rsp_valid is seen.
    task automatic waitRsp(output int lat, input int limit);
        lat = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        compared++;
        if (!rsp_valid) begin
            mismatched++;
            $display("[TB] FAIL rsp_wait: rsp_valid=%0b after %0d cycles, required=1", rsp_valid, lat);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({rsp_valid, req0_ready, req1_ready, busy} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b required 0000", {rsp_valid, req0_ready, req1_ready, busy});
        end
        compared++;
        if ({alu_a, alu_b, alu_mode} !== 19'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_alu: got %h required 0", {alu_a, alu_b, alu_mode});
        end
        compared++;
        if ({rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== 34'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_rsp: got %h required 0", {rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            mismatched++;
            $display("[TB] FAIL reset_first_tie: readys=%b required 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single_add;
        int lat;
        doneMode  = 2;
        rsp_ready = 1'b1;
        issue(1'b0, 3'b000, 8'h05, 8'h03);
        waitRsp(lat, 20);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("[TB] FAIL add_latency: got %0d required 4", lat);
        end
        compared++;
        if ({rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== {1'b0, 8'h08, 8'h00, 16'h0000, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL add_rsp: got %h required %h",
                     {rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err}, {1'b0, 8'h08, 8'h00, 16'h0000, 1'b0});
        end
        compared++;
        if ({alu_a, alu_b, alu_mode} !== {8'h05, 8'h03, 3'b000}) begin
            mismatched++;
            $display("[TB] FAIL add_alu_hold: got %h required %h", {alu_a, alu_b, alu_mode}, {8'h05, 8'h03, 3'b000});
        end
        @(negedge clk);
        compared++;
        if ({rsp_valid, busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL add_back_idle: got %b required 00", {rsp_valid, busy});
        end
    endtask

    task automatic test_tie;
        int lat;
        bit seen;
        logic [33:0] expRsp;
        resetDut();
        doneMode  = 2;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_mode = 3'b010; req0_a = 8'h10; req0_b = 8'h10;
        req1_valid = 1'b1; req1_mode = 3'b011; req1_a = 8'h64; req1_b = 8'h07;
        for (int g = 0; g < 4; g++) begin
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                #1 seen = req0_ready || req1_ready;
                if (!seen) @(negedge clk);
            end
            compared++;
            if ({req0_ready, req1_ready} !== ((g % 2 == 1) ? 2'b01 : 2'b10)) begin
                mismatched++;
                $display("[TB] FAIL tie_grant%0d: readys=%b required %b", g, {req0_ready, req1_ready},
                         (g % 2 == 1) ? 2'b01 : 2'b10);
            end
            @(posedge clk);
            waitRsp(lat, 20);
            expRsp = (g % 2 == 1) ? {1'b1, 8'h0E, 8'h02, 16'h0000, 1'b0}
                                  : {1'b0, 8'h00, 8'h00, 16'h0100, 1'b0};
            compared++;
            if ({rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== expRsp) begin
                mismatched++;
                $display("[TB] FAIL tie_rsp%0d: got %h required %h", g,
                         {rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err}, expRsp);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat;
        logic [37:0] expHold;
        doneMode  = 2;
        rsp_ready = 1'b0;
        issue(1'b1, 3'b000, 8'hF0, 8'h20);
        waitRsp(lat, 20);
        req0_valid = 1'b1; req0_mode = 3'b000; req0_a = 8'h01; req0_b = 8'h01;
        expHold = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h01, 16'h0000, 1'b0};
        for (int i = 0; i < 5; i++) begin
            #1;
            compared++;
            if ({rsp_valid, req0_ready, req1_ready, busy, rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== expHold) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got %h required %h", i,
                         {rsp_valid, req0_ready, req1_ready, busy, rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err}, expHold);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        compared++;
        if ({rsp_valid, busy, req0_ready} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL bp_release: got %b required 001", {rsp_valid, busy, req0_ready});
        end
        req0_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL withdraw_no_grant: busy=%b required 0", busy);
        end
    endtask

    task automatic test_stale_done;
        doneMode  = 1;
        rsp_ready = 1'b1;
        issue(1'b0, 3'b000, 8'h01, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            compared++;
            if ({rsp_valid, busy} !== 2'b01) begin
                mismatched++;
                $display("[TB] FAIL stale_early_c%0d: got %b required 01", k, {rsp_valid, busy});
            end
        end
        @(negedge clk);
        compared++;
        if ({rsp_valid, rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== {1'b1, 1'b0, 8'h03, 8'h00, 16'h0000, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL stale_rsp: got %h required %h",
                     {rsp_valid, rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err},
                     {1'b1, 1'b0, 8'h03, 8'h00, 16'h0000, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int lat;
        doneMode  = 0;
        rsp_ready = 1'b1;
        issue(1'b1, 3'b011, 8'h64, 8'h07);
        waitRsp(lat, 200);
        compared++;
        if (lat !== SETTLE + TIMEOUT + 1) begin
            mismatched++;
            $display("[TB] FAIL timeout_latency: got %0d required %0d", lat, SETTLE + TIMEOUT + 1);
        end
        compared++;
        if ({rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== {1'b1, 8'h00, 8'h00, 16'h0000, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL timeout_rsp: got %h required %h",
                     {rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err}, {1'b1, 8'h00, 8'h00, 16'h0000, 1'b1});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_wait;
        int lat;
        bit sawValid = 1'b0;
        doneMode  = 0;
        rsp_ready = 1'b1;
        issue(1'b0, 3'b010, 8'h11, 8'h22);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        compared++;
        if ({rsp_valid, busy, alu_a, alu_b, alu_mode} !== 21'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_state: got %h required 0", {rsp_valid, busy, alu_a, alu_b, alu_mode});
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) sawValid = 1'b1;
        end
        compared++;
        if (sawValid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_no_rsp: saw rsp_valid=%b required 0", sawValid);
        end
        req1_valid = 1'b1;
        #1;
        compared++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL midreset_req1_grant: readys=%b required 01", {req0_ready, req1_ready});
        end
        doneMode = 2;
        issue(1'b1, 3'b000, 8'h07, 8'h09);
        waitRsp(lat, 20);
        compared++;
        if ({rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err} !== {1'b1, 8'h10, 8'h00, 16'h0000, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL midreset_next_rsp: got %h required %h",
                     {rsp_id, rsp_op1, rsp_op2, rsp_op3, rsp_err}, {1'b1, 8'h10, 8'h00, 16'h0000, 1'b0});
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_tie();
        test_backpressure();
        test_stale_done();
        test_timeout();
        test_reset_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_req_sched.md
# alu_req_sched

Two-port request scheduler placed in front of the shared `ALU` (8-bit add/sub/mul/div/and/or/nor/nand core, registered outputs, `done` flag).
- Accepts operation requests from two independent masters and arbitrates them round-robin.
- Drives the ALU's `a`/`b`/`mode` for one operation at a time and waits out the ALU's output pipeline before trusting `done`.
- Returns `op1`/`op2`/`op3` on a single tagged response channel with valid/ready backpressure and a timeout error.

## Interface
Parameters:
- SETTLE, 2, cycles after issue during which `alu_done` is ignored (legal 2..15; covers the ALU's registered `done`).
- TIMEOUT, 64, max WAIT cycles for `alu_done` before error response (legal 1..255).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid.
- req0_mode / req1_mode  in  3  ALU opcode (ALU mode encoding).
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  originating port (0/1).
- rsp_op1, rsp_op2  out  8  captured ALU op1/op2.
- rsp_op3  out  16  captured ALU op3.
- rsp_err  out  1  1 = timeout, results forced to zero.
- alu_a, alu_b  out  8  operands to ALU.
- alu_mode  out  3  opcode to ALU.
- alu_op1, alu_op2  in  8  ALU results.
- alu_op3  in  16  ALU product.
- alu_done  in  1  ALU completion flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, SETTLE, WAIT, RESP.
- IDLE:
  - Arbiter selects the grant: if only one valid, that port; if both, the port not equal to `last_grant`. `last_grant` resets to 1, so port 0 wins the first tie.
  - Only the selected port's ready is high, combinationally; the other ready is 0. No ready is asserted outside IDLE.
- Accept on valid&ready:
  - Register mode/a/b onto `alu_mode`/`alu_a`/`alu_b`, store id, set `last_grant` = id.
  - Load settle counter with SETTLE and go to SETTLE.
- SETTLE: counter decrements each cycle; `alu_done` is ignored. On the last count go to WAIT and clear the wait counter.
- WAIT, each cycle:
  - If `alu_done`=1: capture `alu_op1`/`alu_op2`/`alu_op3` into the rsp registers, err=0, go to RESP.
  - Otherwise increment the wait counter. When it reaches TIMEOUT, set rsp results to 0 and err=1, go to RESP.
- RESP:
  - rsp_valid=1 with all rsp fields held stable.
  - On rsp_valid&rsp_ready go to IDLE next cycle; a new accept is possible in that IDLE cycle.
- `alu_a`/`alu_b`/`alu_mode` hold the last issued values in every state; they change only at accept.
- Reset values: all rsp outputs 0, req ready 0, `alu_a`/`alu_b`/`alu_mode` 0, busy 0, state IDLE, `last_grant` 1, counters 0.
- Reset mid-operation (any state): return to IDLE next edge. The in-flight op and any pending response are discarded with no rsp_valid.
- Requester deasserting valid without handshake: not granted, no state change.

## Timing
- Accept edge at cycle T; SETTLE occupies T+1..T+SETTLE; first WAIT cycle is T+SETTLE+1.
- Minimum latency: `alu_done` high in the first WAIT cycle gives rsp_valid at T+SETTLE+2 (T+4 at default).
- Timeout: `alu_done` low through WAIT cycles 1..TIMEOUT gives rsp_valid, err=1, at T+SETTLE+TIMEOUT+1.
- `alu_done` held high from a previous op: the first capture is the first WAIT cycle, never earlier.
- Throughput: one op outstanding. Back-to-back accept spacing is ≥ SETTLE+3 cycles with rsp_ready tied high.
- The response handshake and the next accept never occur in the same cycle.

## Test plan
- Single add: req0 mode=000, a=0x05, b=0x03; ALU model asserts done on the 1st WAIT cycle → rsp_valid at T+4, id=0, op1=0x08, op2=0x00, op3=0x0000, err=0.
- Tie arbitration: both ports valid continuously, port 0 mul a=0x10 b=0x10, port 1 div a=0x64 b=0x07.
  - Grants go 0,1,0,1.
  - Port 0 responses: op3=0x0100.
  - Port 1 responses: op1=0x0E, op2=0x02.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp fields stable, both readys 0, busy=1. Raising rsp_ready gives the handshake, then IDLE.
- Stale done: `alu_done` tied high → capture occurs exactly in cycle T+SETTLE+1 and rsp_valid is high at T+SETTLE+2, not before.
- Timeout: `alu_done` tied low, TIMEOUT=64 → rsp_valid at T+67 with err=1 and op1/op2/op3=0.
- Reset during WAIT: assert rst for 1 cycle → next cycle state IDLE, rsp_valid=0, alu_a/alu_b/alu_mode=0, busy=0, no response emitted. A following req1 is granted first only if req0 is idle.
